// File: rtl/aq_gemac_pkg.sv
// Shared constants and types for the AQ GEMAC pause / priority flow control logic.
package aq_gemac_pkg;

  localparam int PFC_MAX_CLASS = 8;
  localparam int PFC_QUANTA_W  = 16;

  typedef enum logic {
    PAUSE_LEGACY = 1'b0,
    PAUSE_PFC    = 1'b1
  } pause_mode_e;

endpackage

// File: rtl/aq_gemac_pfc_timer.sv
// One priority class worth of pause timing: quanta counter, registered
// transmit-inhibit and a one-cycle expiry pulse on natural countdown to zero.
module aq_gemac_pfc_timer
  import aq_gemac_pkg::*;
#(
  parameter int QUANTA_W = PFC_QUANTA_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                load,
  input  logic [QUANTA_W-1:0] load_value,
  input  logic                sub,
  input  logic                enable,
  output logic                apply,
  output logic                expire
);

  logic [QUANTA_W-1:0] count;
  logic                count_nz;
  logic                count_one;

  assign count_nz  = (count != '0);
  assign count_one = (count == QUANTA_W'(1));

  // A load wins over a coincident quantum tick; loading zero is an XON and
  // therefore never reports an expiry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      apply  <= 1'b0;
      expire <= 1'b0;
    end else begin
      if (load) begin
        count <= load_value;
      end else if (sub && count_nz) begin
        count <= count - QUANTA_W'(1);
      end
      apply  <= count_nz & enable;
      expire <= ~load & sub & count_one;
    end
  end

endmodule

// File: rtl/aq_gemac_pfc_ctrl.sv
// Tx-side pause / PFC controller: synchronises the Rx pause request, captures
// the frame's quanta and drives one pause timer per priority class.
module aq_gemac_pfc_ctrl
  import aq_gemac_pkg::*;
#(
  parameter int NUM_CLASS = PFC_MAX_CLASS,
  parameter int QUANTA_W  = PFC_QUANTA_W
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PFC_MODE,
  input  logic [NUM_CLASS-1:0]          TX_PAUSE_ENABLE,
  input  logic [NUM_CLASS*QUANTA_W-1:0] PAUSE_QUANTA,
  input  logic [NUM_CLASS-1:0]          PAUSE_CLASS_VEC,
  input  logic                          PAUSE_QUANTA_VALID,
  output logic                          PAUSE_QUANTA_COMPLETE,
  input  logic                          PAUSE_QUANTA_SUB,
  output logic [NUM_CLASS-1:0]          PAUSE_APPLY,
  output logic                          PAUSE_ANY,
  output logic [NUM_CLASS-1:0]          PAUSE_EXPIRE
);

  logic                          sync1;
  logic                          sync2;
  logic [1:0]                    sync_live;
  logic [NUM_CLASS*QUANTA_W-1:0] quanta_hold;
  logic [NUM_CLASS-1:0]          vec_hold;
  logic                          load_evt;
  pause_mode_e                   mode;

  assign mode = pause_mode_e'(PFC_MODE);

  // sync_live marks when sync2 holds a genuine sample, so a VALID held high
  // across reset is not mistaken for a fresh rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync_live   <= 2'b00;
      quanta_hold <= '0;
      vec_hold    <= '0;
    end else begin
      sync1       <= PAUSE_QUANTA_VALID;
      sync2       <= sync1;
      sync_live   <= {sync_live[0], 1'b1};
      quanta_hold <= PAUSE_QUANTA;
      vec_hold    <= PAUSE_CLASS_VEC;
    end
  end

  assign load_evt              = sync1 & ~sync2 & sync_live[1];
  assign PAUSE_QUANTA_COMPLETE = sync1 & sync2;

  // Legacy pause broadcasts class-0 quanta to every class.
  for (genvar i = 0; i < NUM_CLASS; i++) begin : g_class
    logic                cls_load;
    logic [QUANTA_W-1:0] cls_value;

    assign cls_load  = load_evt & ((mode == PAUSE_LEGACY) | vec_hold[i]);
    assign cls_value = (mode == PAUSE_PFC) ? quanta_hold[i*QUANTA_W +: QUANTA_W]
                                           : quanta_hold[QUANTA_W-1:0];

    aq_gemac_pfc_timer #(
      .QUANTA_W(QUANTA_W)
    ) u_timer (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .load      (cls_load),
      .load_value(cls_value),
      .sub       (PAUSE_QUANTA_SUB),
      .enable    (TX_PAUSE_ENABLE[i]),
      .apply     (PAUSE_APPLY[i]),
      .expire    (PAUSE_EXPIRE[i])
    );
  end

  assign PAUSE_ANY = |PAUSE_APPLY;

endmodule

// File: tb/tb_aq_gemac_pfc_ctrl.sv
// Self-checking bench for aq_gemac_pfc_ctrl: directed pause scenarios plus a
// randomized run, all compared each cycle against a class-counter model.
`timescale 1ns/1ps
module tb_aq_gemac_pfc_ctrl;

  localparam int NC = 8;
  localparam int QW = 16;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             PFC_MODE = 1'b0;
  logic [NC-1:0]    TX_PAUSE_ENABLE = '0;
  logic [NC*QW-1:0] PAUSE_QUANTA = '0;
  logic [NC-1:0]    PAUSE_CLASS_VEC = '0;
  logic             PAUSE_QUANTA_VALID = 1'b0;
  logic             PAUSE_QUANTA_COMPLETE;
  logic             PAUSE_QUANTA_SUB = 1'b0;
  logic [NC-1:0]    PAUSE_APPLY;
  logic             PAUSE_ANY;
  logic [NC-1:0]    PAUSE_EXPIRE;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  aq_gemac_pfc_ctrl #(
    .NUM_CLASS(NC),
    .QUANTA_W (QW)
  ) dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .PFC_MODE             (PFC_MODE),
    .TX_PAUSE_ENABLE      (TX_PAUSE_ENABLE),
    .PAUSE_QUANTA         (PAUSE_QUANTA),
    .PAUSE_CLASS_VEC      (PAUSE_CLASS_VEC),
    .PAUSE_QUANTA_VALID   (PAUSE_QUANTA_VALID),
    .PAUSE_QUANTA_COMPLETE(PAUSE_QUANTA_COMPLETE),
    .PAUSE_QUANTA_SUB     (PAUSE_QUANTA_SUB),
    .PAUSE_APPLY          (PAUSE_APPLY),
    .PAUSE_ANY            (PAUSE_ANY),
    .PAUSE_EXPIRE         (PAUSE_EXPIRE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference: per-class remaining quanta as plain integers. A request is taken
  // on the second edge after VALID is first seen high, and only if the edge
  // before that genuinely saw VALID low after reset.
  int            m_cnt[NC];
  logic [NC-1:0] m_apply;
  logic [NC-1:0] m_expire;
  logic          m_complete;
  int            m_edges;
  logic          m_v1;
  logic          m_v2;
  logic [NC*QW-1:0] m_q1;
  logic [NC-1:0] m_vec1;

  always @(posedge CLK or negedge RST_N) begin
    bit take;
    bit ld;
    int val;
    if (!RST_N) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_apply = '0;
      m_expire = '0;
      m_complete = 1'b0;
      m_edges = 0;
      m_v1 = 1'b0;
      m_v2 = 1'b0;
      m_q1 = '0;
      m_vec1 = '0;
    end else begin
      take = (m_edges >= 2) && m_v1 && !m_v2;
      for (int i = 0; i < NC; i++) begin
        ld  = take && (!PFC_MODE || m_vec1[i]);
        val = PFC_MODE ? int'(m_q1[i*QW +: QW]) : int'(m_q1[QW-1:0]);
        m_expire[i] = PAUSE_QUANTA_SUB && !ld && (m_cnt[i] == 1);
        m_apply[i]  = (m_cnt[i] != 0) && TX_PAUSE_ENABLE[i];
        if (ld) m_cnt[i] = val;
        else if (PAUSE_QUANTA_SUB && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
      m_complete = (m_edges >= 1) && PAUSE_QUANTA_VALID && m_v1;
      m_v2 = m_v1;
      m_v1 = PAUSE_QUANTA_VALID;
      m_q1 = PAUSE_QUANTA;
      m_vec1 = PAUSE_CLASS_VEC;
      if (m_edges < 1000000) m_edges++;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      checkOutput("model_apply", 32'(PAUSE_APPLY), 32'(m_apply));
      checkOutput("model_any", 32'(PAUSE_ANY), 32'(|m_apply));
      checkOutput("model_expire", 32'(PAUSE_EXPIRE), 32'(m_expire));
      checkOutput("model_complete", 32'(PAUSE_QUANTA_COMPLETE), 32'(m_complete));
    end
  end

  task automatic stepCycle();
    @(posedge CLK);
    #2;
  endtask

  // Sends one pause frame, holds VALID until the acknowledge, then keeps VALID
  // low for two edges so the next frame is accepted.
  task automatic applyStimulus(input logic mode, input logic [NC-1:0] vec,
                               input logic [NC*QW-1:0] q, input logic sub_at_load);
    PFC_MODE = mode;
    PAUSE_CLASS_VEC = vec;
    PAUSE_QUANTA = q;
    PAUSE_QUANTA_VALID = 1'b1;
    stepCycle();
    PAUSE_QUANTA_SUB = sub_at_load;
    stepCycle();
    PAUSE_QUANTA_SUB = 1'b0;
    checkOutput("handshake_complete", 32'(PAUSE_QUANTA_COMPLETE), 32'd1);
    PAUSE_QUANTA_VALID = 1'b0;
    stepCycle();
    stepCycle();
  endtask

  task automatic subPulses(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        PAUSE_QUANTA_SUB = 1'b0;
        stepCycle();
      end
      PAUSE_QUANTA_SUB = 1'b1;
      stepCycle();
    end
    PAUSE_QUANTA_SUB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NC*QW-1:0] qv;
    int low_cnt;
    int hold_cnt;

    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("reset_apply", 32'(PAUSE_APPLY), 32'd0);
    checkOutput("reset_expire", 32'(PAUSE_EXPIRE), 32'd0);
    checkOutput("reset_complete", 32'(PAUSE_QUANTA_COMPLETE), 32'd0);
    RST_N = 1'b1;
    cmp_en = 1'b1;
    TX_PAUSE_ENABLE = 8'hFF;
    stepCycle();
    stepCycle();

    // Two PFC classes with different pause lengths.
    qv = '0;
    qv[0*QW +: QW] = 16'd3;
    qv[2*QW +: QW] = 16'd10;
    applyStimulus(1'b1, 8'h05, qv, 1'b0);
    checkOutput("pfc_apply_loaded", 32'(PAUSE_APPLY), 32'h05);
    checkOutput("pfc_any_loaded", 32'(PAUSE_ANY), 32'd1);
    subPulses(3);
    checkOutput("pfc_expire_c0", 32'(PAUSE_EXPIRE), 32'h01);
    stepCycle();
    checkOutput("pfc_apply_c0_off", 32'(PAUSE_APPLY), 32'h04);
    subPulses(7);
    checkOutput("pfc_expire_c2", 32'(PAUSE_EXPIRE), 32'h04);
    stepCycle();
    checkOutput("pfc_apply_all_off", 32'(PAUSE_APPLY), 32'h00);
    checkOutput("pfc_any_off", 32'(PAUSE_ANY), 32'd0);

    // Legacy pause: class 0 quanta broadcast, class vector ignored.
    qv = '0;
    qv[0*QW +: QW] = 16'd2;
    qv[5*QW +: QW] = 16'd9;
    applyStimulus(1'b0, 8'h00, qv, 1'b0);
    checkOutput("legacy_apply", 32'(PAUSE_APPLY), 32'hFF);
    checkOutput("legacy_any", 32'(PAUSE_ANY), 32'd1);
    subPulses(2);
    checkOutput("legacy_expire", 32'(PAUSE_EXPIRE), 32'hFF);
    stepCycle();
    checkOutput("legacy_apply_off", 32'(PAUSE_APPLY), 32'h00);

    // Zero quanta on a running class is an immediate XON without expiry.
    qv = '0;
    qv[1*QW +: QW] = 16'd5;
    applyStimulus(1'b1, 8'h02, qv, 1'b0);
    checkOutput("xon_running", 32'(PAUSE_APPLY), 32'h02);
    qv = '0;
    applyStimulus(1'b1, 8'h02, qv, 1'b0);
    checkOutput("xon_apply_off", 32'(PAUSE_APPLY), 32'h00);
    checkOutput("xon_no_expire", 32'(PAUSE_EXPIRE), 32'h00);

    // Load coincident with a quantum tick: loaded class keeps its value.
    qv = '0;
    qv[3*QW +: QW] = 16'd7;
    applyStimulus(1'b1, 8'h08, qv, 1'b0);
    qv = '0;
    qv[0*QW +: QW] = 16'd4;
    applyStimulus(1'b1, 8'h01, qv, 1'b1);
    checkOutput("coincide_apply", 32'(PAUSE_APPLY), 32'h09);
    subPulses(4);
    checkOutput("coincide_expire_c0", 32'(PAUSE_EXPIRE), 32'h01);
    subPulses(2);
    checkOutput("coincide_expire_c3", 32'(PAUSE_EXPIRE), 32'h08);
    stepCycle();

    // Enable gating does not stop the counter.
    qv = '0;
    qv[2*QW +: QW] = 16'd9;
    applyStimulus(1'b1, 8'h04, qv, 1'b0);
    TX_PAUSE_ENABLE = 8'hFB;
    stepCycle();
    checkOutput("enable_drop", 32'(PAUSE_APPLY), 32'h00);
    subPulses(5);
    checkOutput("enable_still_off", 32'(PAUSE_APPLY), 32'h00);
    TX_PAUSE_ENABLE = 8'hFF;
    stepCycle();
    checkOutput("enable_restore", 32'(PAUSE_APPLY), 32'h04);
    subPulses(4);
    checkOutput("enable_expire", 32'(PAUSE_EXPIRE), 32'h04);
    stepCycle();

    // Reset mid-pause with VALID held high across the reset.
    qv = '0;
    qv[0*QW +: QW] = 16'd20;
    applyStimulus(1'b0, 8'h00, qv, 1'b0);
    checkOutput("prereset_apply", 32'(PAUSE_APPLY), 32'hFF);
    qv[0*QW +: QW] = 16'd30;
    PAUSE_QUANTA = qv;
    PAUSE_QUANTA_VALID = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    checkOutput("midreset_apply", 32'(PAUSE_APPLY), 32'h00);
    checkOutput("midreset_any", 32'(PAUSE_ANY), 32'd0);
    checkOutput("midreset_complete", 32'(PAUSE_QUANTA_COMPLETE), 32'd0);
    stepCycle();
    stepCycle();
    RST_N = 1'b1;
    repeat (5) stepCycle();
    checkOutput("postreset_no_load", 32'(PAUSE_APPLY), 32'h00);
    PAUSE_QUANTA_VALID = 1'b0;
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 8'h00, qv, 1'b0);
    checkOutput("postreset_fresh_load", 32'(PAUSE_APPLY), 32'hFF);

    // Randomized traffic, protocol-legal VALID handshakes.
    low_cnt = 2;
    hold_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      PAUSE_QUANTA_SUB = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) TX_PAUSE_ENABLE = NC'($urandom);
      if ($urandom_range(0, 63) == 0) PFC_MODE = ~PFC_MODE;
      if (PAUSE_QUANTA_VALID) begin
        hold_cnt++;
        if (PAUSE_QUANTA_COMPLETE) begin
          PAUSE_QUANTA_VALID = 1'b0;
          low_cnt = 0;
        end else if (hold_cnt > 20) begin
          checkOutput("complete_timeout", 32'd0, 32'd1);
          PAUSE_QUANTA_VALID = 1'b0;
          low_cnt = 0;
        end
      end else begin
        low_cnt++;
        if (low_cnt >= 2 && $urandom_range(0, 7) == 0) begin
          for (int i = 0; i < NC; i++)
            qv[i*QW +: QW] = ($urandom_range(0, 7) == 0) ? 16'd0 : QW'($urandom_range(1, 24));
          PAUSE_QUANTA = qv;
          PAUSE_CLASS_VEC = NC'($urandom);
          PAUSE_QUANTA_VALID = 1'b1;
          hold_cnt = 0;
        end
      end
      stepCycle();
    end

    PAUSE_QUANTA_VALID = 1'b0;
    PAUSE_QUANTA_SUB = 1'b0;
    stepCycle();
    stepCycle();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aq_gemac_pfc_ctrl.md
AQ_GEMAC_PFC_CTRL -- requirements
Module: aq_gemac_pfc_ctrl

Interface
REQ-001 Parameter NUM_CLASS, default 8, number of priority classes (legal range 1..8).
REQ-002 Parameter QUANTA_W, default 16, width of each pause quanta value and counter.
REQ-003 CLK  input  1  Tx clock; the only clock in the block.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 PFC_MODE  input  1  0 = legacy 802.3x pause (class 0 quanta applies to all classes); 1 = per-class PFC (802.1Qbb).
REQ-006 TX_PAUSE_ENABLE  input  NUM_CLASS  per-class permission to honour received pause.
REQ-007 PAUSE_QUANTA  input  NUM_CLASS*QUANTA_W  flattened quanta from Rx MAC, class i at bits [i*QUANTA_W +: QUANTA_W].
REQ-008 PAUSE_CLASS_VEC  input  NUM_CLASS  class-enable vector of the received PFC frame.
REQ-009 PAUSE_QUANTA_VALID  input  1  level request from Rx domain; data is held stable while high.
REQ-010 PAUSE_QUANTA_COMPLETE  output  1  handshake acknowledge to Rx MAC.
REQ-011 PAUSE_QUANTA_SUB  input  1  one-cycle pulse from Tx MAC per elapsed quantum (512 bit times).
REQ-012 PAUSE_APPLY  output  NUM_CLASS  per-class transmit-inhibit to Tx MAC.
REQ-013 PAUSE_ANY  output  1  OR of PAUSE_APPLY.
REQ-014 PAUSE_EXPIRE  output  NUM_CLASS  one-cycle pulse when a class counter decrements from 1 to 0.

Function
REQ-015 PAUSE_QUANTA_VALID shall pass through a two-flop synchronizer (sync1, sync2); PAUSE_QUANTA and PAUSE_CLASS_VEC shall be registered every cycle into holding registers.
REQ-016 A load event shall occur in the cycle where sync1=1 and sync2=0 (rising edge), using the holding-register values.
REQ-017 PAUSE_QUANTA_COMPLETE shall equal sync1 AND sync2; Rx MAC drops VALID after COMPLETE, and a new load requires VALID low for at least two cycles.
REQ-018 On load with PFC_MODE=1, each class i with PAUSE_CLASS_VEC[i]=1 shall load its own quanta; classes with bit 0 shall be unaffected.
REQ-019 On load with PFC_MODE=0, every class counter shall load class-0 quanta; PAUSE_CLASS_VEC shall be ignored.
REQ-020 A loaded quanta of 0 shall clear that counter (immediate XON).
REQ-021 Without load, a class counter shall decrement by 1 when PAUSE_QUANTA_SUB=1 and counter != 0; it shall hold at 0 (no wrap).
REQ-022 Load and SUB in the same cycle: loaded classes take the new value (no decrement); non-loaded classes decrement.
REQ-023 Counters shall run regardless of TX_PAUSE_ENABLE.
REQ-024 PAUSE_APPLY[i] shall be registered as (counter[i] != 0) AND TX_PAUSE_ENABLE[i], i.e. one cycle after the counter or enable changes.
REQ-025 PAUSE_EXPIRE[i] shall pulse one cycle after a 1->0 decrement; a load-to-0 shall not raise PAUSE_EXPIRE.
REQ-026 PAUSE_ANY shall be combinational OR of the registered PAUSE_APPLY bits.
REQ-027 PFC_MODE change shall affect only subsequent load events; running counters shall be kept.

Reset
REQ-028 RST_N low shall asynchronously clear synchronizer flops, holding registers, all counters, PAUSE_APPLY, PAUSE_EXPIRE and PAUSE_QUANTA_COMPLETE to 0.
REQ-029 Reset asserted mid-pause shall release all classes immediately; after reset no load shall occur until a fresh VALID rising edge is seen.

Structure
REQ-030 Constants PFC_MAX_CLASS=8 and default QUANTA_W=16 shall live in the shared package aq_gemac_pkg.
REQ-031 The per-class counter, apply and expire logic shall be one sub-module aq_gemac_pfc_timer, instantiated NUM_CLASS times by generate.
REQ-032 Synchronizer, holding registers and handshake logic shall remain in the top module.

Verification
REQ-033 PFC_MODE=1, VEC=8'h05, quanta[0]=3, quanta[2]=10, enable=8'hFF -> APPLY=8'h05 after load; 3 SUB pulses -> APPLY[0] low and EXPIRE[0] pulse; APPLY[2] low after 10 SUB pulses.
REQ-034 PFC_MODE=0, quanta[0]=2, VEC=0 -> all 8 APPLY bits high, PAUSE_ANY=1; after 2 SUB pulses APPLY=0, EXPIRE=8'hFF.
REQ-035 Class 1 running at count 5, new frame VEC=8'h02 quanta[1]=0 -> APPLY[1] low two cycles later, no EXPIRE pulse.
REQ-036 Load coincident with SUB, class 0 loaded with 4, class 3 at 7 not loaded -> class 0=4, class 3=6.
REQ-037 Enable[2] dropped while counter[2]=9 -> APPLY[2] low next cycle, counter keeps decrementing; enable restored at count 4 -> APPLY[2] high again.
REQ-038 RST_N pulsed low with all counters nonzero -> all outputs 0 immediately; VALID held high through reset release -> no load until VALID goes low then high.
